instr_stream_encoder: RTL and testbench

- Encoder counterpart to the core's instruction decoder: takes abstract operation requests (kind, rd, rs1, rs2, imm) and emits RV32I machine words.
- Covers the subset the core decodes: ADDI, BNE, ADD, SUB, AND, OR, SLT.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from a base address.
- Used by the boot/test loader to build programs for the single-cycle core.

---
 rtl/instr_enc_pkg.sv | 71 +++++++
 rtl/instr_enc_fifo.sv | 64 ++++++
 rtl/instr_stream_encoder.sv | 124 ++++++++++++
 tb/tb_instr_stream_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// ============================================================================
// Module   : instr_enc_pkg
// Purpose  : Shared types, RV32I field constants and the word encoder for
//            instr_stream_encoder. Macro INSTR_ENC_STD_SLT_EN selects the
//            ratified SLT funct3 (010) instead of the core's 101.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_enc_pkg;

    typedef enum logic [2:0] {
        ADDI = 3'd0,
        BNE  = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        AND  = 3'd4,
        OR   = 3'd5,
        SLT  = 3'd6,
        RSVD = 3'd7
    } op_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BNE = 3'b001;
`ifdef INSTR_ENC_STD_SLT_EN
    localparam logic [2:0] F3_SLT = 3'b010;
`else
    localparam logic [2:0] F3_SLT = 3'b101;
`endif

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    function automatic logic [31:0] encode_instr(
        input op_kind_t    kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] word;
        word = '0;
        case (kind)
            ADDI: word = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
            BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE,
                          imm[4:1], imm[11], OPC_BRANCH};
            ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_OP};
            AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
            SLT:  word = {F7_BASE, rs2, rs1, F3_SLT, rd, OPC_OP};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_enc_fifo.sv
// ============================================================================
// Module   : instr_enc_fifo
// Purpose  : Show-ahead synchronous FIFO for encoded instruction words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_enc_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_level;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_level == (c_ptr_w+1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign rdata  = r_mem[r_rd_ptr];

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_ptr_w+1)'(1);
                2'b01:   r_level <= r_level - (c_ptr_w+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_stream_encoder.sv
// ============================================================================
// Module   : instr_stream_encoder
// Purpose  : Encodes operation requests into RV32I words and streams them into
//            instruction memory from a base address. Honours macro
//            INSTR_ENC_STD_SLT_EN (SLT funct3 selection, see instr_enc_pkg).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_stream_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  op_kind_t              req_kind,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [12:0]           req_imm,
    input  logic                  req_last,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] count
);

    enc_state_t            r_state;
    enc_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_err;
    logic                  r_last_seen;
    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_write;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [31:0]           w_word;

    assign w_start_ok = start & (r_state != ST_RUN);
    assign w_accept   = req_valid & req_ready;
    assign w_reject   = (req_kind == RSVD) | ((req_kind == BNE) & req_imm[0]);
    assign w_word     = encode_instr(req_kind, req_rd, req_rs1, req_rs2, req_imm);
    assign w_write    = mem_we & mem_ready;

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign req_ready = busy & ~w_fifo_full & ~r_last_seen;
    assign mem_we    = busy & ~w_fifo_empty;
    assign mem_addr  = r_addr;
    assign err       = r_err;
    assign count     = r_count;

    instr_enc_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept & ~w_reject),
        .wdata (w_word),
        .pop   (w_write),
        .rdata (mem_wdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An empty FIFO in RUN also means no write is outstanding.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_last_seen && w_fifo_empty) w_state_next = ST_DONE;
            ST_DONE: if (start) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
        end else if (w_start_ok) begin
            r_addr      <= base_addr;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            if (w_write) begin
                r_addr  <= r_addr + ADDR_WIDTH'(4);
                r_count <= r_count + ADDR_WIDTH'(1);
            end
            if (w_accept) begin
                if (w_reject) r_err <= 1'b1;
                if (req_last) r_last_seen <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
// ============================================================================
// Module   : tb_instr_stream_encoder
// Purpose  : Scoreboard bench for instr_stream_encoder with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_stream_encoder;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    op_kind_t    req_kind = ADDI;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [12:0] req_imm = '0;
    logic        req_last = 1'b0;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] count;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_addr [$];
    logic [31:0] sb_data [$];
    logic [31:0] exp_addr = '0;

    logic        stalled = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] held_data = '0;

`ifdef INSTR_ENC_STD_SLT_EN
    localparam logic [31:0] c_slt_word = 32'h0073A2B3;
`else
    localparam logic [31:0] c_slt_word = 32'h0073D2B3;
`endif

    instr_stream_encoder #(
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .req_last  (req_last),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed write against the scoreboard and
    // verifies the write side holds steady while stalled.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (stalled) begin
                chk("stall_addr_stable", mem_addr, held_addr);
                chk("stall_data_stable", mem_wdata, held_data);
            end
            if (mem_ready) begin
                stalled = 1'b0;
                if (sb_addr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", mem_addr, sb_addr.pop_front());
                    chk("wr_data", mem_wdata, sb_data.pop_front());
                end
            end else begin
                stalled   = 1'b1;
                held_addr = mem_addr;
                held_data = mem_wdata;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
        exp_addr  = b;
    endtask

    task automatic send(input op_kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic last,
                        input logic ok, input logic [31:0] word);
        bit got = 1'b0;
        @(negedge clk);
        req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_imm = imm; req_last = last; req_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
        end else if (ok) begin
            sb_addr.push_back(exp_addr);
            sb_data.push_back(word);
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_err"},       {31'd0, err},       32'd0);
        chk({tag, "_count"},     count,              32'd0);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADDI x1,x0,5 with last
        do_start(32'h100);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        send(ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b1, 32'h00500093);
        wait_done("done_addi");
        chk("count_addi", count, 32'd1);
        chk("err_addi", {31'd0, err}, 32'd0);
        chk("busy_in_done", {31'd0, busy}, 32'd0);

        // ADD / SUB back to back
        do_start(32'h100);
        chk("count_cleared", count, 32'd0);
        send(ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h002081B3);
        send(SUB, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b1, 32'h402081B3);
        wait_done("done_addsub");
        chk("count_addsub", count, 32'd2);

        // BNE good, then reserved and misaligned BNE rejected
        do_start(32'h200);
        send(BNE, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b0, 1'b1, 32'hFE209CE3);
        send(RSVD, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 1'b0, 32'd0);
        send(BNE, 5'd0, 5'd1, 5'd2, 13'd3, 1'b1, 1'b0, 32'd0);
        wait_done("done_bne");
        chk("err_bne", {31'd0, err}, 32'd1);
        chk("count_bne", count, 32'd1);

        // Stall with a full FIFO
        do_start(32'h300);
        chk("err_cleared", {31'd0, err}, 32'd0);
        #1 mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(ADDI, 5'd1, 5'd0, 5'd0, 13'(i), 1'b0, 1'b1, 32'h00000093 | (32'(i) << 20));
        end
        chk("ready_low_when_full", {31'd0, req_ready}, 32'd0);
        chk("stall_we", {31'd0, mem_we}, 32'd1);
        chk("stall_addr", mem_addr, 32'h300);
        chk("stall_data", mem_wdata, 32'h00100093);
        fork
            send(ADDI, 5'd1, 5'd0, 5'd0, 13'd6, 1'b1, 1'b1, 32'h00600093);
            begin
                repeat (6) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        wait_done("done_stall");
        chk("count_stall", count, 32'd5);

        // SLT
        do_start(32'h400);
        send(SLT, 5'd5, 5'd7, 5'd7, 13'd0, 1'b1, 1'b1, c_slt_word);
        wait_done("done_slt");

        // Address and count wrap
        do_start(32'hFFFF_FFFC);
        send(ADDI, 5'd2, 5'd0, 5'd0, 13'd7, 1'b0, 1'b1, 32'h00700113);
        send(ADDI, 5'd2, 5'd0, 5'd0, 13'd8, 1'b1, 1'b1, 32'h00800113);
        wait_done("done_wrap");
        chk("addr_wrapped", mem_addr, 32'h4);

        // Reset in the middle of a load with two words queued
        do_start(32'h500);
        #1 mem_ready = 1'b0;
        send(ADDI, 5'd1, 5'd0, 5'd0, 13'd9, 1'b0, 1'b1, 32'h00900093);
        send(ADDI, 5'd1, 5'd0, 5'd0, 13'd10, 1'b0, 1'b1, 32'h00A00093);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        sb_addr.delete();
        sb_data.delete();
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("fifo_empty_after_reset", {31'd0, mem_we}, 32'd0);
        do_start(32'h600);
        send(ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b1, 32'h00500093);
        wait_done("done_reload");
        chk("count_reload", count, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_addr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
